alarm_trigger: RTL and testbench

ALARM_TRIGGER -- requirements
Module: alarm_trigger

---
 rtl/alarm_trigger.sv | 122 ++++++++++++
 tb/tb_alarm_trigger.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_trigger.sv
// Alarm trigger controller: arms on ALM_EN and rings when the programmed
// hour/minute arrives at second 0. A ring ends on dismiss, on timeout, or
// when it is snoozed. A snoozed alarm rings again after a fixed delay.
module alarm_trigger #(
    parameter int unsigned TIMEOUT_SEC = 60,
    parameter int unsigned SNOOZE_MIN  = 5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SEC_TICK,
    input  logic [4:0] CUR_HOUR,
    input  logic [5:0] CUR_MIN,
    input  logic [5:0] CUR_SEC,
    input  logic [4:0] ALM_HOUR,
    input  logic [5:0] ALM_MIN,
    input  logic       ALM_EN,
    input  logic       DISMISS,
    input  logic       SNOOZE,
    output logic       ALARM_ACTIVE,
    output logic       ALARM_EVENT,
    output logic       SNOOZED
);

    localparam logic [15:0] RING_LAST   = 16'(TIMEOUT_SEC - 1);
    localparam logic [15:0] SNOOZE_LOAD = 16'(SNOOZE_MIN * 60);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        RINGING,
        SNOOZING,
        DONE
    } state_t;

    state_t      state, state_next;
    logic [15:0] ring_cnt, ring_cnt_next;
    logic [15:0] snooze_cnt, snooze_cnt_next;
    logic        same_minute;
    logic        match;

    // Time comparison; an alarm time outside 0..23 / 0..59 can never match.
    always_comb begin
        same_minute = (CUR_HOUR == ALM_HOUR) && (CUR_MIN == ALM_MIN);
        match       = same_minute && (CUR_SEC == 6'd0)
                      && (ALM_HOUR <= 5'd23) && (ALM_MIN <= 6'd59);
    end

    // Next-state and counter update; ALM_EN low overrides everything.
    always_comb begin
        state_next      = state;
        ring_cnt_next   = ring_cnt;
        snooze_cnt_next = snooze_cnt;
        if (!ALM_EN) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = ARMED;
                ARMED: begin
                    if (match) begin
                        state_next    = RINGING;
                        ring_cnt_next = '0;
                    end
                end
                RINGING: begin
                    // User requests outrank a coincident timeout tick.
                    if (DISMISS) begin
                        state_next = DONE;
                    end else if (SNOOZE) begin
                        state_next      = SNOOZING;
                        snooze_cnt_next = SNOOZE_LOAD;
                    end else if (SEC_TICK) begin
                        if (ring_cnt == RING_LAST) begin
                            state_next = DONE;
                        end else begin
                            ring_cnt_next = ring_cnt + 16'd1;
                        end
                    end
                end
                SNOOZING: begin
                    if (DISMISS) begin
                        state_next = DONE;
                    end else if (SEC_TICK) begin
                        if (snooze_cnt == 16'd1) begin
                            state_next    = RINGING;
                            ring_cnt_next = '0;
                        end else begin
                            snooze_cnt_next = snooze_cnt - 16'd1;
                        end
                    end
                end
                DONE: begin
                    // Stay put for the rest of the alarm minute to avoid a retrigger.
                    if (!same_minute) begin
                        state_next = ARMED;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State/counter registers; outputs are registered from the next state so
    // they line up with the state register in the same cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            ring_cnt     <= '0;
            snooze_cnt   <= '0;
            ALARM_ACTIVE <= 1'b0;
            ALARM_EVENT  <= 1'b0;
            SNOOZED      <= 1'b0;
        end else begin
            state        <= state_next;
            ring_cnt     <= ring_cnt_next;
            snooze_cnt   <= snooze_cnt_next;
            ALARM_ACTIVE <= (state_next == RINGING);
            ALARM_EVENT  <= (state_next == RINGING) && (state != RINGING);
            SNOOZED      <= (state_next == SNOOZING);
        end
    end

endmodule

// File: tb/tb_alarm_trigger.sv
// Testbench for alarm_trigger: directed scenarios plus randomized stimulus
// compared against a behavioural model of the alarm rules.
module tb_alarm_trigger;

    localparam int unsigned T_SEC = 3;
    localparam int unsigned S_MIN = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sec_tick = 1'b0;
    logic [4:0] cur_hour = '0;
    logic [5:0] cur_min = '0;
    logic [5:0] cur_sec = '0;
    logic [4:0] alm_hour = '0;
    logic [5:0] alm_min = '0;
    logic       alm_en = 1'b0;
    logic       dismiss = 1'b0;
    logic       snooze = 1'b0;
    logic       alarm_active, alarm_event, snoozed;

    int checks = 0;
    int failures = 0;

    alarm_trigger #(.TIMEOUT_SEC(T_SEC), .SNOOZE_MIN(S_MIN)) dut (
        .CLK(clk), .RESET(rst), .SEC_TICK(sec_tick),
        .CUR_HOUR(cur_hour), .CUR_MIN(cur_min), .CUR_SEC(cur_sec),
        .ALM_HOUR(alm_hour), .ALM_MIN(alm_min), .ALM_EN(alm_en),
        .DISMISS(dismiss), .SNOOZE(snooze),
        .ALARM_ACTIVE(alarm_active), .ALARM_EVENT(alarm_event), .SNOOZED(snoozed)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode plus "ticks remaining" budgets.
    typedef enum int {M_IDLE, M_ARMED, M_RING, M_SNOOZE, M_DONE} mmode_t;
    mmode_t m_mode = M_IDLE;
    int     ring_left = 0;
    int     snooze_left = 0;
    bit     m_event = 1'b0;

    task automatic model_step();
        bit hit;
        hit = (cur_hour == alm_hour) && (cur_min == alm_min) && (cur_sec == 6'd0)
              && (int'(alm_hour) < 24) && (int'(alm_min) < 60);
        m_event = 1'b0;
        if (rst || !alm_en) begin
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE:  m_mode = M_ARMED;
                M_ARMED: if (hit) begin m_mode = M_RING; ring_left = int'(T_SEC); m_event = 1'b1; end
                M_RING: begin
                    if (dismiss) m_mode = M_DONE;
                    else if (snooze) begin m_mode = M_SNOOZE; snooze_left = int'(S_MIN) * 60; end
                    else if (sec_tick) begin
                        ring_left = ring_left - 1;
                        if (ring_left == 0) m_mode = M_DONE;
                    end
                end
                M_SNOOZE: begin
                    if (dismiss) m_mode = M_DONE;
                    else if (sec_tick) begin
                        snooze_left = snooze_left - 1;
                        if (snooze_left == 0) begin m_mode = M_RING; ring_left = int'(T_SEC); m_event = 1'b1; end
                    end
                end
                M_DONE: if (cur_hour != alm_hour || cur_min != alm_min) m_mode = M_ARMED;
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic bump_time();
        if (cur_sec == 6'd59) begin
            cur_sec = 6'd0;
            if (cur_min == 6'd59) begin
                cur_min = 6'd0;
                cur_hour = (cur_hour == 5'd23) ? 5'd0 : cur_hour + 5'd1;
            end else begin
                cur_min = cur_min + 6'd1;
            end
        end else begin
            cur_sec = cur_sec + 6'd1;
        end
    endtask

    task automatic sec();
        bump_time();
        sec_tick = 1'b1;
        clk1();
        sec_tick = 1'b0;
    endtask

    task automatic ring_up();
        rst = 1'b1; clk1(); rst = 1'b0;
        alm_en = 1'b1; alm_hour = 5'd7; alm_min = 6'd30;
        cur_hour = 5'd7; cur_min = 6'd29; cur_sec = 6'd59;
        clk1();
        cur_min = 6'd30; cur_sec = 6'd0;
        clk1();
    endtask

    task automatic test_reset();
        rst = 1'b1; clk1(); clk1();
        checks++; if (alarm_active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", alarm_active); end
        checks++; if (alarm_event !== 1'b0) begin failures++; $display("FAIL reset_event got=%b exp=0", alarm_event); end
        checks++; if (snoozed !== 1'b0) begin failures++; $display("FAIL reset_snoozed got=%b exp=0", snoozed); end
        rst = 1'b0;
    endtask

    task automatic test_ring_timeout();
        rst = 1'b1; clk1(); rst = 1'b0;
        alm_en = 1'b1; alm_hour = 5'd7; alm_min = 6'd30;
        cur_hour = 5'd7; cur_min = 6'd29; cur_sec = 6'd58;
        clk1();
        sec();
        checks++; if (alarm_active !== 1'b0) begin failures++; $display("FAIL pre_match_active got=%b exp=0", alarm_active); end
        sec();
        checks++; if (alarm_active !== 1'b1) begin failures++; $display("FAIL match_active got=%b exp=1", alarm_active); end
        checks++; if (alarm_event !== 1'b1) begin failures++; $display("FAIL match_event got=%b exp=1", alarm_event); end
        clk1();
        checks++; if (alarm_event !== 1'b0) begin failures++; $display("FAIL event_width got=%b exp=0", alarm_event); end
        sec(); sec();
        checks++; if (alarm_active !== 1'b1) begin failures++; $display("FAIL active_after_2_ticks got=%b exp=1", alarm_active); end
        sec();
        checks++; if (alarm_active !== 1'b0) begin failures++; $display("FAIL timeout_3rd_tick got=%b exp=0", alarm_active); end
        while (cur_sec != 6'd59) begin
            sec();
            checks++; if (alarm_active !== 1'b0 || alarm_event !== 1'b0) begin failures++; $display("FAIL no_retrigger at sec %0d got=%b/%b exp=0/0", cur_sec, alarm_active, alarm_event); end
        end
        sec();
        alm_min = 6'd31;
        clk1();
        checks++; if (alarm_active !== 1'b1) begin failures++; $display("FAIL rearm_next_minute got=%b exp=1", alarm_active); end
    endtask

    task automatic test_snooze();
        ring_up();
        snooze = 1'b1; clk1(); snooze = 1'b0;
        checks++; if (snoozed !== 1'b1 || alarm_active !== 1'b0) begin failures++; $display("FAIL snooze_entry got=%b/%b exp=1/0", snoozed, alarm_active); end
        repeat (59) sec();
        checks++; if (snoozed !== 1'b1 || alarm_active !== 1'b0) begin failures++; $display("FAIL snooze_59_ticks got=%b/%b exp=1/0", snoozed, alarm_active); end
        sec();
        checks++; if (alarm_active !== 1'b1 || alarm_event !== 1'b1 || snoozed !== 1'b0) begin failures++; $display("FAIL snooze_expire got=%b%b%b exp=110", alarm_active, alarm_event, snoozed); end
        clk1();
        checks++; if (alarm_event !== 1'b0) begin failures++; $display("FAIL resnooze_event_width got=%b exp=0", alarm_event); end
        dismiss = 1'b1; clk1(); dismiss = 1'b0;
        checks++; if (alarm_active !== 1'b0 || snoozed !== 1'b0) begin failures++; $display("FAIL dismiss_after_snooze got=%b/%b exp=0/0", alarm_active, snoozed); end
    endtask

    task automatic test_both();
        ring_up();
        dismiss = 1'b1; snooze = 1'b1; clk1(); dismiss = 1'b0; snooze = 1'b0;
        checks++; if (alarm_active !== 1'b0 || snoozed !== 1'b0) begin failures++; $display("FAIL both_pulses got=%b/%b exp=0/0", alarm_active, snoozed); end
        repeat (3) clk1();
        checks++; if (alarm_active !== 1'b0 || snoozed !== 1'b0) begin failures++; $display("FAIL done_holds got=%b/%b exp=0/0", alarm_active, snoozed); end
    endtask

    task automatic test_timeout_priority();
        ring_up();
        sec(); sec();
        snooze = 1'b1; sec(); snooze = 1'b0;
        checks++; if (snoozed !== 1'b1 || alarm_active !== 1'b0) begin failures++; $display("FAIL snooze_beats_timeout got=%b/%b exp=1/0", snoozed, alarm_active); end
    endtask

    task automatic test_en_drop();
        ring_up();
        snooze = 1'b1; clk1(); snooze = 1'b0;
        checks++; if (snoozed !== 1'b1) begin failures++; $display("FAIL en_drop_pre got=%b exp=1", snoozed); end
        alm_en = 1'b0; clk1();
        checks++; if (alarm_active !== 1'b0 || alarm_event !== 1'b0 || snoozed !== 1'b0) begin failures++; $display("FAIL en_drop got=%b%b%b exp=000", alarm_active, alarm_event, snoozed); end
        alm_en = 1'b1; clk1();
        checks++; if (alarm_active !== 1'b0) begin failures++; $display("FAIL en_raise_armed got=%b exp=0", alarm_active); end
        clk1();
        checks++; if (alarm_active !== 1'b1 || alarm_event !== 1'b1) begin failures++; $display("FAIL en_raise_ring got=%b/%b exp=1/1", alarm_active, alarm_event); end
    endtask

    task automatic test_reset_midring();
        ring_up();
        sec();
        cur_sec = 6'd0;
        rst = 1'b1; clk1();
        checks++; if (alarm_active !== 1'b0 || alarm_event !== 1'b0 || snoozed !== 1'b0) begin failures++; $display("FAIL reset_midring got=%b%b%b exp=000", alarm_active, alarm_event, snoozed); end
        rst = 1'b0; clk1();
        checks++; if (alarm_active !== 1'b0) begin failures++; $display("FAIL reset_rearm_cycle got=%b exp=0", alarm_active); end
        clk1();
        checks++; if (alarm_active !== 1'b1 || alarm_event !== 1'b1) begin failures++; $display("FAIL reset_restart got=%b/%b exp=1/1", alarm_active, alarm_event); end
    endtask

    task automatic test_out_of_range();
        rst = 1'b1; clk1(); rst = 1'b0;
        alm_en = 1'b1; alm_hour = 5'd24; alm_min = 6'd0;
        cur_hour = 5'd24; cur_min = 6'd0; cur_sec = 6'd0;
        repeat (4) clk1();
        checks++; if (alarm_active !== 1'b0) begin failures++; $display("FAIL bad_hour_match got=%b exp=0", alarm_active); end
        alm_hour = 5'd23; alm_min = 6'd60; cur_hour = 5'd23; cur_min = 6'd60;
        repeat (4) clk1();
        checks++; if (alarm_active !== 1'b0) begin failures++; $display("FAIL bad_min_match got=%b exp=0", alarm_active); end
    endtask

    task automatic test_random();
        bit exp_a, exp_s;
        rst = 1'b1; clk1(); rst = 1'b0;
        for (int seg = 0; seg < 30; seg++) begin
            alm_hour = ($urandom % 8 == 0) ? 5'(24 + $urandom % 8) : 5'($urandom % 24);
            alm_min  = ($urandom % 8 == 0) ? 6'(60 + $urandom % 4) : 6'($urandom % 60);
            cur_hour = alm_hour;
            case ($urandom % 3)
                0: begin cur_min = alm_min; cur_sec = 6'd0; end
                1: begin cur_min = alm_min; cur_sec = 6'(1 + $urandom % 59); end
                default: begin cur_min = alm_min - 6'd1; cur_sec = 6'(55 + $urandom % 5); end
            endcase
            for (int c = 0; c < 200; c++) begin
                rst     = ($urandom % 300 == 0);
                alm_en  = ($urandom % 150 != 0);
                dismiss = ($urandom % 40 == 0);
                snooze  = ($urandom % 25 == 0);
                sec_tick = ($urandom % 2 == 0);
                if (sec_tick) bump_time();
                clk1();
                exp_a = (m_mode == M_RING);
                exp_s = (m_mode == M_SNOOZE);
                checks++; if (alarm_active !== exp_a) begin failures++; $display("FAIL rnd_active seg=%0d cyc=%0d got=%b exp=%b", seg, c, alarm_active, exp_a); end
                checks++; if (alarm_event !== m_event) begin failures++; $display("FAIL rnd_event seg=%0d cyc=%0d got=%b exp=%b", seg, c, alarm_event, m_event); end
                checks++; if (snoozed !== exp_s) begin failures++; $display("FAIL rnd_snoozed seg=%0d cyc=%0d got=%b exp=%b", seg, c, snoozed, exp_s); end
            end
        end
        rst = 1'b0; dismiss = 1'b0; snooze = 1'b0; sec_tick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ring_timeout();
        test_snooze();
        test_both();
        test_timeout_priority();
        test_en_drop();
        test_reset_midring();
        test_out_of_range();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
